// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation encodings and control states.
package alu_pkg;

    typedef enum logic [3:0] {
        M_SHL   = 4'd0,
        M_SHR   = 4'd1,
        M_SRA   = 4'd2,
        M_ADD   = 4'd3,
        M_SUB   = 4'd4,
        M_AND   = 4'd5,
        M_OR    = 4'd6,
        M_XOR   = 4'd7,
        M_XNOR  = 4'd8,
        M_NOR   = 4'd9,
        M_NOT   = 4'd10,
        M_DEC   = 4'd11,
        M_PASSA = 4'd12,
        M_PASSB = 4'd13,
        M_MSB   = 4'd14,
        M_MUL   = 4'd15
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam int GRP = 4;

endpackage

// File: rtl/cla_adder.sv
// Carry-lookahead adder: 4-bit lookahead groups, group carries rippled
// from one group to the next.
module cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [3:0]       w_gg;
    logic [3:0]       w_gp;
    logic             w_c0;
    logic             w_c1;
    logic             w_c2;
    logic             w_c3;
    logic             w_cg;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        s    = '0;
        w_gg = '0;
        w_gp = '0;
        w_c0 = cin;
        w_c1 = 1'b0;
        w_c2 = 1'b0;
        w_c3 = 1'b0;
        w_cg = 1'b0;
        for (int k = 0; k < NG; k++) begin
            w_gg = w_g[4*k +: 4];
            w_gp = w_p[4*k +: 4];
            w_c1 = w_gg[0] | (w_gp[0] & w_c0);
            w_c2 = w_gg[1] | (w_gp[1] & w_gg[0])
                 | (&w_gp[1:0] & w_c0);
            w_c3 = w_gg[2] | (w_gp[2] & w_gg[1])
                 | (&w_gp[2:1] & w_gg[0])
                 | (&w_gp[2:0] & w_c0);
            w_cg = w_gg[3] | (w_gp[3] & w_gg[2])
                 | (&w_gp[3:2] & w_gg[1])
                 | (&w_gp[3:1] & w_gg[0])
                 | (&w_gp[3:0] & w_c0);
            s[4*k +: 4] = w_gp ^ {w_c3, w_c2, w_c1, w_c0};
            w_c0 = w_cg;
        end
        cout = w_c0;
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/shift/add ops, iterative shift-add
// multiply, valid/ready handshakes on both sides.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    state_e             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_y;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHW-1:0]     r_cnt;

    mode_e              w_mode;
    logic               w_accept;
    logic               w_is_sub;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_ci;
    logic [WIDTH-1:0]   w_sum;
    logic               w_add_co;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_prod;

    assign w_mode   = mode_e'(mode);
    assign in_ready = (r_state == S_IDLE)
                    | ((r_state == S_HOLD) & out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_is_sub = (w_mode == M_SUB);
    assign w_add_b  = w_is_sub ? ~b : b;
    assign w_add_ci = w_is_sub ? 1'b1 : cin;
    assign w_sh     = b[SHW-1:0];

    cla_adder #(
        .WIDTH(WIDTH)
    ) u_cla (
        .a   (a),
        .b   (w_add_b),
        .cin (w_add_ci),
        .s   (w_sum),
        .cout(w_add_co)
    );

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        unique case (w_mode)
            M_SHL:   w_res = a << w_sh;
            M_SHR:   w_res = a >> w_sh;
            M_SRA:   w_res = $unsigned($signed(a) >>> w_sh);
            M_ADD: begin
                w_res = w_sum;
                w_c   = w_add_co;
                w_v   = (a[WIDTH-1] == b[WIDTH-1])
                      & (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            M_SUB: begin
                w_res = w_sum;
                w_c   = w_add_co;
                w_v   = (a[WIDTH-1] != b[WIDTH-1])
                      & (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            M_AND:   w_res = a & b;
            M_OR:    w_res = a | b;
            M_XOR:   w_res = a ^ b;
            M_XNOR:  w_res = ~(a ^ b);
            M_NOR:   w_res = ~(a | b);
            M_NOT:   w_res = ~a;
            M_DEC:   w_res = {{(WIDTH-1){1'b0}}, 1'b1} << a[SHW-1:0];
            M_PASSA: w_res = a;
            M_PASSB: w_res = b;
            M_MSB: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (a[i]) w_res = WIDTH'(i);
                end
                w_v = (a == '0);
            end
            M_MUL:   w_res = '0;
        endcase
    end

    // one partial product per cycle; multiplicand shifts up as multiplier drains
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod    = w_acc_nxt[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            if (w_mode == M_MUL) begin
                r_state     <= S_MUL;
                r_out_valid <= 1'b0;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_mcand     <= {{WIDTH{1'b0}}, a};
                r_mplier    <= b;
            end else begin
                r_state     <= S_HOLD;
                r_out_valid <= 1'b1;
                r_y         <= w_res;
                r_cout      <= w_c;
                r_ovf       <= w_v;
                r_zero      <= (w_res == '0);
                r_neg       <= w_res[WIDTH-1];
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                end
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + SHW'(1);
                    if (r_cnt == SHW'(WIDTH-1)) begin
                        r_state     <= S_HOLD;
                        r_out_valid <= 1'b1;
                        r_y         <= w_prod;
                        r_cout      <= 1'b0;
                        r_ovf       <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                        r_zero      <= (w_prod == '0);
                        r_neg       <= w_prod[WIDTH-1];
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
    assign negative  = r_neg;

endmodule
